// File: rtl/mem_wb_pkg.sv
// Shared types and constants for the memory-access / write-back stage.
package mem_wb_pkg;

    localparam int unsigned ADDR_W_DEF = 18;
    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned REG_W      = 5;
    localparam int unsigned TMR_W      = 8;

    localparam logic [REG_W-1:0] REG_ZERO = '0;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    function automatic logic is_aligned(input logic [1:0] byte_lsb);
        return byte_lsb == 2'b00;
    endfunction

endpackage

// File: rtl/memory_writeback_mc_req_timer.sv
// Counts cycles spent in REQ and flags when the controller has been waited on too long.
module mc_req_timer
    import mem_wb_pkg::*;
#(
    parameter int unsigned MC_TIMEOUT = 15
) (
    input  logic clock,
    input  logic reset,
    input  logic start,
    input  logic busy,
    output logic timeout_hit
);

    logic [TMR_W-1:0] count;

    // count holds the number of REQ cycles including the current one
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (start) begin
            count <= TMR_W'(1);
        end else if (busy) begin
            count <= count + TMR_W'(1);
        end else begin
            count <= '0;
        end
    end

    assign timeout_hit = busy && (count == TMR_W'(MC_TIMEOUT));

endmodule

// File: rtl/memory_writeback.sv
// Memory-access and write-back stage: issues load/store requests to the memory
// controller, stalls upstream while one is outstanding, and drives the register file write port.
module memory_writeback
    import mem_wb_pkg::*;
#(
    parameter int unsigned ADDR_W     = ADDR_W_DEF,
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned MC_TIMEOUT = 15
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ex_mem_readmem,
    input  logic              ex_mem_writemem,
    input  logic [DATA_W-1:0] ex_mem_regb,
    input  logic              ex_mem_selwsource,
    input  logic [REG_W-1:0]  ex_mem_regdest,
    input  logic              ex_mem_writereg,
    input  logic [DATA_W-1:0] ex_mem_wbvalue,
    output logic              mem_ex_stall,
    output logic              mem_mc_en,
    output logic              mem_mc_we,
    output logic [ADDR_W-1:0] mem_mc_addr,
    output logic [DATA_W-1:0] mem_mc_wdata,
    input  logic              mc_mem_ready,
    input  logic [DATA_W-1:0] mc_mem_rdata,
    output logic              wb_reg_en,
    output logic [REG_W-1:0]  wb_reg_addr,
    output logic [DATA_W-1:0] wb_reg_data,
    output logic              mem_fault
);

    state_t state, state_d;

    logic              memop, aligned, timeout_hit, timer_start;
    logic              en_d, we_d, wb_en_d, fault_d;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] wdata_d, wb_data_d;
    logic [REG_W-1:0]  wb_addr_d;

    // write-back intent captured at issue, consumed when the controller answers
    logic              pend_wb, pend_wb_d;
    logic              pend_sel, pend_sel_d;
    logic [REG_W-1:0]  pend_dest, pend_dest_d;
    logic [DATA_W-1:0] pend_val, pend_val_d;

    assign memop   = ex_mem_readmem | ex_mem_writemem;
    assign aligned = is_aligned(ex_mem_wbvalue[1:0]);

    mc_req_timer #(
        .MC_TIMEOUT (MC_TIMEOUT)
    ) u_timer (
        .clock       (clock),
        .reset       (reset),
        .start       (timer_start),
        .busy        (state == REQ),
        .timeout_hit (timeout_hit)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d      = state;
        mem_ex_stall = 1'b0;
        timer_start  = 1'b0;
        en_d         = mem_mc_en;
        we_d         = mem_mc_we;
        addr_d       = mem_mc_addr;
        wdata_d      = mem_mc_wdata;
        wb_en_d      = 1'b0;
        wb_addr_d    = wb_reg_addr;
        wb_data_d    = wb_reg_data;
        fault_d      = 1'b0;
        pend_wb_d    = pend_wb;
        pend_sel_d   = pend_sel;
        pend_dest_d  = pend_dest;
        pend_val_d   = pend_val;

        unique case (state)
            IDLE: begin
                en_d = 1'b0;
                if (memop) begin
                    if (aligned) begin
                        mem_ex_stall = 1'b1;
                        timer_start  = 1'b1;
                        state_d      = REQ;
                        en_d         = 1'b1;
                        we_d         = ex_mem_writemem;
                        addr_d       = ex_mem_wbvalue[ADDR_W+1:2];
                        wdata_d      = ex_mem_regb;
                        // a store wins over a simultaneous load and never writes back
                        pend_wb_d    = ex_mem_readmem & ~ex_mem_writemem & ex_mem_writereg
                                       & (ex_mem_regdest != REG_ZERO);
                        pend_sel_d   = ex_mem_selwsource;
                        pend_dest_d  = ex_mem_regdest;
                        pend_val_d   = ex_mem_wbvalue;
                    end else begin
                        fault_d = 1'b1;
                    end
                end else if (ex_mem_writereg && (ex_mem_regdest != REG_ZERO)) begin
                    wb_en_d   = 1'b1;
                    wb_addr_d = ex_mem_regdest;
                    wb_data_d = ex_mem_wbvalue;
                end
            end
            REQ: begin
                if (mc_mem_ready) begin
                    state_d = IDLE;
                    en_d    = 1'b0;
                    if (pend_wb) begin
                        wb_en_d   = 1'b1;
                        wb_addr_d = pend_dest;
                        wb_data_d = pend_sel ? mc_mem_rdata : pend_val;
                    end
                end else if (timeout_hit) begin
                    state_d = IDLE;
                    en_d    = 1'b0;
                    fault_d = 1'b1;
                end else begin
                    mem_ex_stall = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem_mc_en    <= 1'b0;
            mem_mc_we    <= 1'b0;
            mem_mc_addr  <= '0;
            mem_mc_wdata <= '0;
            wb_reg_en    <= 1'b0;
            wb_reg_addr  <= '0;
            wb_reg_data  <= '0;
            mem_fault    <= 1'b0;
            pend_wb      <= 1'b0;
            pend_sel     <= 1'b0;
            pend_dest    <= '0;
            pend_val     <= '0;
        end else begin
            mem_mc_en    <= en_d;
            mem_mc_we    <= we_d;
            mem_mc_addr  <= addr_d;
            mem_mc_wdata <= wdata_d;
            wb_reg_en    <= wb_en_d;
            wb_reg_addr  <= wb_addr_d;
            wb_reg_data  <= wb_data_d;
            mem_fault    <= fault_d;
            pend_wb      <= pend_wb_d;
            pend_sel     <= pend_sel_d;
            pend_dest    <= pend_dest_d;
            pend_val     <= pend_val_d;
        end
    end

endmodule

// File: doc/memory_writeback.md
# memory_writeback

Combined memory-access and write-back stage of the five-stage pipeline, between the execute stage and the register file write port. It takes the ex_mem_* bundle, performs load/store transactions against the data memory controller with a request/ready handshake, and stalls upstream while a transaction is outstanding. It drives the register file's write port (enable, address, data), the write direction that complements the decode stage's register reads.

## Interface
Parameters:
- ADDR_W, 18, word-address width toward the memory controller
- DATA_W, 32, data word width
- MC_TIMEOUT, 15, REQ cycles without ready before the transaction is aborted (range 1..255)

Ports:
- clock  in  1  single clock; all state updates on posedge
- reset  in  1  asynchronous, active-low reset
- ex_mem_readmem  in  1  load request
- ex_mem_writemem  in  1  store request
- ex_mem_regb  in  DATA_W  store data
- ex_mem_selwsource  in  1  1 = write-back from memory read data, 0 = from ex_mem_wbvalue
- ex_mem_regdest  in  5  destination register
- ex_mem_writereg  in  1  register write requested
- ex_mem_wbvalue  in  DATA_W  ALU result; byte address for loads/stores
- mem_ex_stall  out  1  upstream must hold the ex_mem_* bundle stable while high
- mem_mc_en  out  1  memory request valid
- mem_mc_we  out  1  1 = write, 0 = read
- mem_mc_addr  out  ADDR_W  word address = ex_mem_wbvalue[ADDR_W+1:2]
- mem_mc_wdata  out  DATA_W  store data
- mc_mem_ready  in  1  memory completes the transaction in this cycle
- mc_mem_rdata  in  DATA_W  read data, valid when mc_mem_ready is high
- wb_reg_en  out  1  register file write enable
- wb_reg_addr  out  5  register file write address
- wb_reg_data  out  DATA_W  register file write data
- mem_fault  out  1  one-cycle pulse on misaligned access or timeout

## Operation
- Two states: IDLE, REQ.
- memop = ex_mem_readmem | ex_mem_writemem. Aligned means ex_mem_wbvalue[1:0] == 0.
- IDLE, no memop: at the edge, if ex_mem_writereg is high and ex_mem_regdest != 0, then wb_reg_en=1, wb_reg_addr=regdest, wb_reg_data=wbvalue. Otherwise wb_reg_en=0.
- IDLE, memop, misaligned: no request, no write-back, mem_fault pulses at the next edge, no stall.
- IDLE, memop, aligned: go to REQ. Register en=1, we=writemem, addr, wdata. Both readmem and writemem high means write wins.
- REQ: hold en, we, addr, wdata stable. The timeout counter increments each cycle.
  - On mc_mem_ready, go to IDLE and drop en.
  - For a read with writereg=1, selwsource=1 and regdest != 0, write back rdata on the next cycle.
  - A read with selwsource=0 writes back wbvalue.
  - A store never writes back.
- REQ timeout: when the counter reaches MC_TIMEOUT with ready still low, go to IDLE, drop en, pulse mem_fault, and skip write-back.
- Every write-back is a one-cycle wb_reg_en pulse. Register 0 is never written.

## Timing
- Reset (asynchronous, immediate): state=IDLE, counter=0. Every output is 0: mem_mc_en, mem_mc_we, mem_mc_addr, mem_mc_wdata, wb_reg_en, wb_reg_addr, wb_reg_data, mem_fault. Reset during REQ abandons the transaction with no write-back.
- mem_ex_stall is combinational: (IDLE & memop & aligned) | (REQ & ~mc_mem_ready & ~timeout_hit).
  - Upstream advances on an edge where stall is low.
  - A single-op request therefore never re-issues.
- Non-memory op: write-back one edge after it is presented, with zero stall cycles.
- Load: presented in cycle 0, en high from cycle 1, ready in cycle k≥1, write-back visible in cycle k+1. Stall covers cycles 0..k-1, so the minimum is one stall cycle.
- Store: same shape without write-back.
- Timeout: en is high for exactly MC_TIMEOUT cycles. mem_fault is high in the cycle after the last of those.
- ready while IDLE is ignored.

## Structure
- Package mem_wb_pkg:
  - state enum {IDLE, REQ}
  - ADDR_W and DATA_W defaults
  - regdest width 5
  - REG_ZERO constant
- One natural sub-module, mc_req_timer: a counter that is cleared on entry to REQ, counts while in REQ, and flags timeout_hit at MC_TIMEOUT.

## Test plan
- ALU op: writereg=1, regdest=5, wbvalue=0x0000_00AA, no memop → next cycle wb_reg_en=1, addr=5, data=0xAA. Stall never high.
- Load: readmem=1, selwsource=1, writereg=1, regdest=8, wbvalue=0x40, ready after 3 cycles with rdata=0xDEAD_BEEF → mem_mc_addr=0x10 and en high for 3 cycles, stall high for 3 cycles, then wb_reg_en=1, addr=8, data=0xDEADBEEF.
- Store: writemem=1, wbvalue=0x100, regb=0x1234, ready in the first REQ cycle → addr=0x40, we=1, wdata=0x1234, one stall cycle, wb_reg_en stays 0.
- Faults:
  - Load with wbvalue=0x42 → no en, mem_fault pulse, no write-back.
  - Aligned load with ready held low → en high for 15 cycles, then mem_fault pulse, no write-back.
- Reset/reg-0: reset asserted in the second REQ cycle → all outputs 0 at once and no write-back after release. Separately, writereg=1 with regdest=0 → wb_reg_en stays 0.
